// File: rtl/regfile_scoreboard.sv
// Register file with per-register in-flight write counters, WB bypass on reads,
// RAW/saturation issue stall, kill path and a saturating stall-cycle counter.
module regfile_scoreboard #(
  parameter int unsigned DBITS     = 32,
  parameter int unsigned REGNOBITS = 5,
  parameter int unsigned NREAD     = 2,
  parameter int unsigned CNTBITS   = 2,
  parameter int unsigned PERFBITS  = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREAD*REGNOBITS-1:0] rd_addr,
  input  logic [NREAD-1:0]           rd_used,
  output logic [NREAD*DBITS-1:0]     rd_data,
  output logic [NREAD-1:0]           rd_busy,
  input  logic                       issue_valid,
  input  logic                       issue_wr,
  input  logic [REGNOBITS-1:0]       issue_rd,
  output logic                       issue_ready,
  input  logic                       wb_valid,
  input  logic [REGNOBITS-1:0]       wb_rd,
  input  logic [DBITS-1:0]           wb_data,
  input  logic                       kill_valid,
  input  logic [REGNOBITS-1:0]       kill_rd,
  output logic [PERFBITS-1:0]        stall_count,
  output logic                       sb_error
);

  localparam int unsigned NREGS = 2**REGNOBITS;
  localparam int unsigned CW    = CNTBITS + 1;
  localparam logic [CNTBITS-1:0] CNT_MAX = '1;
  localparam logic [CNTBITS-1:0] CNT_ONE = CNTBITS'(1);

  logic [DBITS-1:0]     regs    [NREGS];
  logic [CNTBITS-1:0]   cnt     [NREGS];
  logic [CNTBITS-1:0]   cnt_nxt [NREGS];
  logic [REGNOBITS-1:0] a;
  logic                 last_wb;
  logic                 sat;
  logic                 fire;
  logic                 uflow;
  logic [CW-1:0]        sum;
  logic [CW-1:0]        dec;

  // A port whose final pending write lands this cycle is served by the bypass.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    a       = '0;
    last_wb = 1'b0;
    for (int unsigned i = 0; i < NREAD; i++) begin
      a       = rd_addr[i*REGNOBITS +: REGNOBITS];
      last_wb = (cnt[a] == CNT_ONE) && wb_valid && (wb_rd == a) &&
                !(kill_valid && (kill_rd == a));
      if (a != '0) begin
        rd_data[i*DBITS +: DBITS] = (wb_valid && (wb_rd == a)) ? wb_data : regs[a];
        rd_busy[i]                = (cnt[a] != '0) && !last_wb;
      end
    end
  end

  always_comb begin
    sat         = issue_wr && (issue_rd != '0) && (cnt[issue_rd] == CNT_MAX);
    issue_ready = !(|(rd_used & rd_busy)) && !sat;
    fire        = issue_valid && issue_ready && issue_wr && (issue_rd != '0);
  end

  // Increment and both decrements are summed per register; a net negative clamps to 0.
  always_comb begin
    uflow = 1'b0;
    sum   = '0;
    dec   = '0;
    for (int unsigned r = 0; r < NREGS; r++) begin
      cnt_nxt[r] = cnt[r];
      if (r != 0) begin
        sum = {1'b0, cnt[r]} + CW'(fire && (issue_rd == REGNOBITS'(r)));
        dec = CW'(wb_valid && (wb_rd == REGNOBITS'(r))) +
              CW'(kill_valid && (kill_rd == REGNOBITS'(r)));
        if (dec > sum) begin
          cnt_nxt[r] = '0;
          uflow      = 1'b1;
        end else begin
          cnt_nxt[r] = CNTBITS'(sum - dec);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
        cnt[r]  <= '0;
      end
      stall_count <= '0;
      sb_error    <= 1'b0;
    end else begin
      if (wb_valid && (wb_rd != '0)) regs[wb_rd] <= wb_data;
      for (int unsigned r = 0; r < NREGS; r++) cnt[r] <= cnt_nxt[r];
      if (issue_valid && !issue_ready && (stall_count != '1))
        stall_count <= stall_count + 1'b1;
      if (uflow) sb_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard (stall counter narrowed to 4 bits).
module tb_regfile_scoreboard;

  localparam int unsigned DBITS = 32;
  localparam int unsigned RB    = 5;
  localparam int unsigned NR    = 2;
  localparam int unsigned PB    = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [NR*RB-1:0] rd_addr;
  logic [NR-1:0]    rd_used;
  logic [NR*DBITS-1:0] rd_data;
  logic [NR-1:0]    rd_busy;
  logic             issue_valid, issue_wr, issue_ready;
  logic [RB-1:0]    issue_rd;
  logic             wb_valid;
  logic [RB-1:0]    wb_rd;
  logic [DBITS-1:0] wb_data;
  logic             kill_valid;
  logic [RB-1:0]    kill_rd;
  logic [PB-1:0]    stall_count;
  logic             sb_error;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_scoreboard #(
    .DBITS(DBITS), .REGNOBITS(RB), .NREAD(NR), .CNTBITS(2), .PERFBITS(PB)
  ) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_used(rd_used),
    .rd_data(rd_data), .rd_busy(rd_busy), .issue_valid(issue_valid),
    .issue_wr(issue_wr), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .kill_valid(kill_valid), .kill_rd(kill_rd),
    .stall_count(stall_count), .sb_error(sb_error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_addr = '0; rd_used = '0;
    issue_valid = 1'b0; issue_wr = 1'b0; issue_rd = '0;
    wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    kill_valid = 1'b0; kill_rd = '0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    rd_addr = {5'd31, 5'd5};
    tick(); tick();
    reset = 1'b0;
    #1;
    n_checks++; if (rd_data !== 64'h0) begin n_fail++; $display("FAIL reset_rd_data got %h exp 0", rd_data); end
    n_checks++; if (rd_busy !== 2'b00) begin n_fail++; $display("FAIL reset_rd_busy got %b exp 00", rd_busy); end
    n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL reset_issue_ready got %b exp 1", issue_ready); end
    n_checks++; if (stall_count !== 4'd0) begin n_fail++; $display("FAIL reset_stall_count got %0d exp 0", stall_count); end
    n_checks++; if (sb_error !== 1'b0) begin n_fail++; $display("FAIL reset_sb_error got %b exp 0", sb_error); end
  endtask

  task automatic test_raw_bypass();
    idle();
    issue_valid = 1'b1; issue_wr = 1'b1; issue_rd = 5'd3;
    #1;
    n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL raw_first_ready got %b exp 1", issue_ready); end
    tick();
    issue_wr = 1'b0; rd_addr = {5'd0, 5'd3}; rd_used = 2'b01;
    #1;
    n_checks++; if (rd_busy[0] !== 1'b1) begin n_fail++; $display("FAIL raw_busy got %b exp 1", rd_busy[0]); end
    n_checks++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL raw_stall_ready got %b exp 0", issue_ready); end
    tick();
    n_checks++; if (stall_count !== 4'd1) begin n_fail++; $display("FAIL raw_stall_cnt1 got %0d exp 1", stall_count); end
    tick();
    n_checks++; if (stall_count !== 4'd2) begin n_fail++; $display("FAIL raw_stall_cnt2 got %0d exp 2", stall_count); end
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEADBEEF;
    #1;
    n_checks++; if (rd_busy[0] !== 1'b0) begin n_fail++; $display("FAIL bypass_busy got %b exp 0", rd_busy[0]); end
    n_checks++; if (rd_data[31:0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL bypass_data got %h exp deadbeef", rd_data[31:0]); end
    n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL bypass_ready got %b exp 1", issue_ready); end
    tick();
    idle(); rd_addr = {5'd0, 5'd3};
    #1;
    n_checks++; if (rd_busy[0] !== 1'b0) begin n_fail++; $display("FAIL raw_after_busy got %b exp 0", rd_busy[0]); end
    n_checks++; if (rd_data[31:0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL raw_after_data got %h exp deadbeef", rd_data[31:0]); end
    n_checks++; if (stall_count !== 4'd2) begin n_fail++; $display("FAIL raw_after_stall got %0d exp 2", stall_count); end
  endtask

  task automatic test_multi_inflight();
    idle();
    issue_valid = 1'b1; issue_wr = 1'b1; issue_rd = 5'd7;
    tick(); tick(); tick();
    issue_valid = 1'b0;
    #1;
    n_checks++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL multi_sat_ready got %b exp 0", issue_ready); end
    wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h70;
    #1;
    n_checks++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL multi_sat_pre_update got %b exp 0", issue_ready); end
    tick();
    wb_valid = 1'b0; rd_addr = {5'd0, 5'd7};
    #1;
    n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL multi_ready_after_wb got %b exp 1", issue_ready); end
    n_checks++; if (rd_busy[0] !== 1'b1) begin n_fail++; $display("FAIL multi_busy_cnt2 got %b exp 1", rd_busy[0]); end
    wb_valid = 1'b1; wb_data = 32'h71;
    #1;
    n_checks++; if (rd_busy[0] !== 1'b1) begin n_fail++; $display("FAIL multi_busy_wb2 got %b exp 1", rd_busy[0]); end
    tick();
    wb_valid = 1'b0;
    #1;
    n_checks++; if (rd_busy[0] !== 1'b1) begin n_fail++; $display("FAIL multi_busy_cnt1 got %b exp 1", rd_busy[0]); end
    wb_valid = 1'b1; wb_data = 32'h72;
    #1;
    n_checks++; if (rd_busy[0] !== 1'b0) begin n_fail++; $display("FAIL multi_final_busy got %b exp 0", rd_busy[0]); end
    n_checks++; if (rd_data[31:0] !== 32'h72) begin n_fail++; $display("FAIL multi_final_data got %h exp 72", rd_data[31:0]); end
    tick();
    wb_valid = 1'b0;
    #1;
    n_checks++; if (rd_busy[0] !== 1'b0) begin n_fail++; $display("FAIL multi_idle_busy got %b exp 0", rd_busy[0]); end
    n_checks++; if (rd_data[31:0] !== 32'h72) begin n_fail++; $display("FAIL multi_reg_data got %h exp 72", rd_data[31:0]); end
  endtask

  task automatic test_simultaneous();
    idle();
    issue_valid = 1'b1; issue_wr = 1'b1; issue_rd = 5'd4;
    tick();
    wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 32'h44;
    #1;
    n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL simul_ready got %b exp 1", issue_ready); end
    tick();
    idle(); rd_addr = {5'd0, 5'd4};
    #1;
    n_checks++; if (rd_busy[0] !== 1'b1) begin n_fail++; $display("FAIL simul_busy got %b exp 1", rd_busy[0]); end
    n_checks++; if (rd_data[31:0] !== 32'h44) begin n_fail++; $display("FAIL simul_data got %h exp 44", rd_data[31:0]); end
    wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 32'h45;
    #1;
    n_checks++; if (rd_busy[0] !== 1'b0) begin n_fail++; $display("FAIL simul_cnt_is_one got %b exp 0", rd_busy[0]); end
    tick();
    idle();
    issue_valid = 1'b1; issue_wr = 1'b1; issue_rd = 5'd10;
    tick(); tick();
    idle(); rd_addr = {5'd0, 5'd10};
    wb_valid = 1'b1; wb_rd = 5'd10; wb_data = 32'hA0;
    kill_valid = 1'b1; kill_rd = 5'd10;
    #1;
    n_checks++; if (rd_busy[0] !== 1'b1) begin n_fail++; $display("FAIL kill_wb_busy got %b exp 1", rd_busy[0]); end
    tick();
    idle(); rd_addr = {5'd0, 5'd10};
    #1;
    n_checks++; if (rd_busy[0] !== 1'b0) begin n_fail++; $display("FAIL kill_wb_cleared got %b exp 0", rd_busy[0]); end
    n_checks++; if (sb_error !== 1'b0) begin n_fail++; $display("FAIL kill_wb_error got %b exp 0", sb_error); end
  endtask

  task automatic test_reg0();
    idle();
    issue_valid = 1'b1; issue_wr = 1'b1; issue_rd = 5'd0;
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'h55;
    kill_valid = 1'b1; kill_rd = 5'd0;
    rd_addr = {5'd0, 5'd0}; rd_used = 2'b11;
    #1;
    n_checks++; if (rd_data !== 64'h0) begin n_fail++; $display("FAIL x0_bypass_data got %h exp 0", rd_data); end
    n_checks++; if (rd_busy !== 2'b00) begin n_fail++; $display("FAIL x0_busy got %b exp 00", rd_busy); end
    n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL x0_ready got %b exp 1", issue_ready); end
    tick();
    idle(); rd_used = 2'b11;
    #1;
    n_checks++; if (rd_data !== 64'h0) begin n_fail++; $display("FAIL x0_data got %h exp 0", rd_data); end
    n_checks++; if (rd_busy !== 2'b00) begin n_fail++; $display("FAIL x0_busy_after got %b exp 00", rd_busy); end
    n_checks++; if (sb_error !== 1'b0) begin n_fail++; $display("FAIL x0_error got %b exp 0", sb_error); end
  endtask

  task automatic test_underflow();
    idle();
    wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h99;
    tick();
    idle(); rd_addr = {5'd0, 5'd9};
    #1;
    n_checks++; if (rd_data[31:0] !== 32'h99) begin n_fail++; $display("FAIL uflow_data got %h exp 99", rd_data[31:0]); end
    n_checks++; if (sb_error !== 1'b1) begin n_fail++; $display("FAIL uflow_error got %b exp 1", sb_error); end
    n_checks++; if (rd_busy[0] !== 1'b0) begin n_fail++; $display("FAIL uflow_busy got %b exp 0", rd_busy[0]); end
    tick(); tick();
    n_checks++; if (sb_error !== 1'b1) begin n_fail++; $display("FAIL uflow_sticky got %b exp 1", sb_error); end
  endtask

  task automatic test_unused_and_saturation();
    idle();
    issue_valid = 1'b1; issue_wr = 1'b1; issue_rd = 5'd3;
    tick();
    issue_wr = 1'b0; rd_addr = {5'd3, 5'd0}; rd_used = 2'b00;
    #1;
    n_checks++; if (rd_busy[1] !== 1'b1) begin n_fail++; $display("FAIL unused_busy got %b exp 1", rd_busy[1]); end
    n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL unused_ready got %b exp 1", issue_ready); end
    rd_used = 2'b10;
    #1;
    n_checks++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL used_ready got %b exp 0", issue_ready); end
    for (int k = 0; k < 13; k++) tick();
    n_checks++; if (stall_count !== 4'hF) begin n_fail++; $display("FAIL stall_full got %0d exp 15", stall_count); end
    tick(); tick();
    n_checks++; if (stall_count !== 4'hF) begin n_fail++; $display("FAIL stall_saturate got %0d exp 15", stall_count); end
    idle();
    reset = 1'b1;
    rd_addr = {5'd3, 5'd9};
    tick();
    reset = 1'b0;
    #1;
    n_checks++; if (sb_error !== 1'b0) begin n_fail++; $display("FAIL rereset_error got %b exp 0", sb_error); end
    n_checks++; if (stall_count !== 4'd0) begin n_fail++; $display("FAIL rereset_stall got %0d exp 0", stall_count); end
    n_checks++; if (rd_data !== 64'h0) begin n_fail++; $display("FAIL rereset_data got %h exp 0", rd_data); end
    n_checks++; if (rd_busy !== 2'b00) begin n_fail++; $display("FAIL rereset_busy got %b exp 00", rd_busy); end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    #1;
    test_reset();
    test_raw_bypass();
    test_multi_inflight();
    test_simultaneous();
    test_reg0();
    test_underflow();
    test_unused_and_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
